// File: rtl/door_latch_ctrl.sv
// -----------------------------------------------------------------------------
// door_latch_ctrl
//
// Downstream stage of the serial-code lock. Turns the lock's single-cycle
// unlock pulse into a timed latch-release window, watches the door sensor,
// and raises an alarm on forced entry or when the door is held open too long.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-low reset
//   unlock        in   single-cycle unlock pulse from the lock FSM
//   door_open     in   raw door sensor (1 = open), asynchronous to clk
//   ack           in   operator alarm acknowledge (level)
//   latch_release out  1 = latch solenoid energised (state RELEASE)
//   alarm         out  1 = alarm active (state ALARM)
//   state         out  debug view of the FSM state (00/01/10/11 =
//                      LOCKED/RELEASE/OPEN/ALARM)
//   unlock_count  out  [CNT_W-1:0] saturating count of accepted unlocks,
//                      present only when DOOR_LATCH_UNLOCK_COUNT_EN is defined
//
// Optional feature macro: DOOR_LATCH_UNLOCK_COUNT_EN
// -----------------------------------------------------------------------------
module door_latch_ctrl #(
  parameter int RELEASE_CYCLES  = 8,
  parameter int OPEN_MAX_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       unlock,
  input  logic       door_open,
  input  logic       ack,
  output logic       latch_release,
  output logic       alarm,
  output logic [1:0] state
`ifdef DOOR_LATCH_UNLOCK_COUNT_EN
  ,
  output logic [CNT_W-1:0] unlock_count
`endif
);

  localparam int MAX_CYCLES = (RELEASE_CYCLES > OPEN_MAX_CYCLES) ?
                              RELEASE_CYCLES : OPEN_MAX_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES) + 1;

  localparam logic [TIMER_W-1:0] RELEASE_LOAD = TIMER_W'(RELEASE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OPEN_LOAD    = TIMER_W'(OPEN_MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    LOCKED  = 2'b00,
    RELEASE = 2'b01,
    OPEN    = 2'b10,
    ALARM   = 2'b11
  } state_t;

  state_t             state_q;
  logic [TIMER_W-1:0] timer;
  logic               sync_meta;
  logic               door_s;

  // Two-flop synchronizer for the asynchronous door sensor; the FSM only
  // ever looks at door_s.
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= 1'b0;
      door_s    <= 1'b0;
    end else begin
      sync_meta <= door_open;
      door_s    <= sync_meta;
    end
  end

  // Main FSM. Outputs are registered alongside the state so each output is a
  // clean flop with no decode glitch; every branch that changes state also
  // sets the outputs that belong to the destination state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= LOCKED;
      timer         <= '0;
      latch_release <= 1'b0;
      alarm         <= 1'b0;
    end else begin
      case (state_q)
        LOCKED: begin
          // Door seen open while locked is forced entry, even if an unlock
          // arrives in the same cycle.
          if (door_s) begin
            state_q <= ALARM;
            alarm   <= 1'b1;
          end else if (unlock) begin
            state_q       <= RELEASE;
            timer         <= RELEASE_LOAD;
            latch_release <= 1'b1;
          end
        end

        RELEASE: begin
          if (door_s) begin
            state_q       <= OPEN;
            timer         <= OPEN_LOAD;
            latch_release <= 1'b0;
          end else if (unlock) begin
            // Another valid code while waiting restarts the full window.
            timer <= RELEASE_LOAD;
          end else if (timer == '0) begin
            state_q       <= LOCKED;
            latch_release <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        OPEN: begin
          if (!door_s) begin
            state_q <= LOCKED;
          end else if (timer == '0) begin
            state_q <= ALARM;
            alarm   <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        ALARM: begin
          // Acknowledge only clears the alarm once the door is shut.
          if (ack && !door_s) begin
            state_q <= LOCKED;
            alarm   <= 1'b0;
          end
        end

        default: begin
          state_q       <= LOCKED;
          latch_release <= 1'b0;
          alarm         <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef DOOR_LATCH_UNLOCK_COUNT_EN
  // Counts only LOCKED->RELEASE entries; window extensions are not new
  // unlocks. Saturates rather than wrapping.
  logic accept_unlock;
  assign accept_unlock = (state_q == LOCKED) && !door_s && unlock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unlock_count <= '0;
    end else if (accept_unlock && (unlock_count != {CNT_W{1'b1}})) begin
      unlock_count <= unlock_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_door_latch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_door_latch_ctrl
//
// Scoreboard bench for door_latch_ctrl. The stimulus process drives inputs on
// the falling edge, advances a behavioural model of the door controller by one
// rising edge, and queues the expected outputs. An independent monitor pops
// one expectation after every rising edge and compares it with the DUT.
// Define DOOR_LATCH_UNLOCK_COUNT_EN for both files to cover unlock_count.
// -----------------------------------------------------------------------------
module tb_door_latch_ctrl;

  localparam int REL = 8;
  localparam int OPN = 16;
  localparam int CW  = 2;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       unlock    = 1'b0;
  logic       door_open = 1'b0;
  logic       ack       = 1'b0;
  logic       latch_release;
  logic       alarm;
  logic [1:0] state;
`ifdef DOOR_LATCH_UNLOCK_COUNT_EN
  logic [CW-1:0] unlock_count;
`endif

  door_latch_ctrl #(
    .RELEASE_CYCLES (REL),
    .OPEN_MAX_CYCLES(OPN),
    .CNT_W          (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .unlock       (unlock),
    .door_open    (door_open),
    .ack          (ack),
    .latch_release(latch_release),
    .alarm        (alarm),
    .state        (state)
`ifdef DOOR_LATCH_UNLOCK_COUNT_EN
    ,
    .unlock_count (unlock_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: tracks the door situation and counts elapsed cycles
  // upward; the sensor delay is a FIFO of past door samples.
  // ---------------------------------------------------------------------------
  typedef enum int {M_LOCKED, M_RELEASE, M_OPEN, M_ALARM} mode_t;

  typedef struct {
    int st;
    int lr;
    int al;
    int cnt;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  mode_t mode;
  int    rel_used;    // cycles spent in the current release window
  int    open_used;   // cycles the door has been seen open
  int    cnt;
  bit    door_pipe[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    len;
  bit    dr;

  function automatic int mode_code(mode_t m);
    case (m)
      M_LOCKED:  return 0;
      M_RELEASE: return 1;
      M_OPEN:    return 2;
      default:   return 3;
    endcase
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e.st  = mode_code(mode);
    e.lr  = (mode == M_RELEASE) ? 1 : 0;
    e.al  = (mode == M_ALARM) ? 1 : 0;
    e.cnt = cnt;
    return e;
  endfunction

  function automatic void model_reset();
    mode      = M_LOCKED;
    rel_used  = 0;
    open_used = 0;
    cnt       = 0;
    door_pipe = {1'b0, 1'b0};
  endfunction

  // One rising edge of the controller.
  function automatic void model_edge(bit u, bit d, bit a);
    bit seen;
    seen = door_pipe.pop_front();   // door as sampled two edges ago
    door_pipe.push_back(d);
    case (mode)
      M_LOCKED: begin
        if (seen) mode = M_ALARM;
        else if (u) begin
          mode     = M_RELEASE;
          rel_used = 1;
          if (cnt < (1 << CW) - 1) cnt++;
        end
      end
      M_RELEASE: begin
        if (seen) begin
          mode      = M_OPEN;
          open_used = 1;
        end else if (u) rel_used = 1;
        else if (rel_used >= REL) mode = M_LOCKED;
        else rel_used++;
      end
      M_OPEN: begin
        if (!seen) mode = M_LOCKED;
        else if (open_used >= OPN) mode = M_ALARM;
        else open_used++;
      end
      default: begin
        if (a && !seen) mode = M_LOCKED;
      end
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input bit u, input bit d, input bit a);
    @(negedge clk);
    rst       = 1'b1;
    unlock    = u;
    door_open = d;
    ack       = a;
    model_edge(u, d, a);
    exp_q.push_back(expected());
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b0;
      unlock    = 1'b0;
      door_open = 1'b0;
      ack       = 1'b0;
      model_reset();
      exp_q.push_back(expected());
      if (i == 0) begin
        // Asynchronous clear must be visible before any clock edge.
        #1;
        check("rst_latch_release", int'(latch_release), 0);
        check("rst_state", int'(state), 0);
        check("rst_alarm", int'(alarm), 0);
`ifdef DOOR_LATCH_UNLOCK_COUNT_EN
        check("rst_unlock_count", int'(unlock_count), 0);
`endif
      end
    end
  endtask

  task automatic idle(input int n, input bit d, input bit a);
    for (int i = 0; i < n; i++) step(1'b0, d, a);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one expectation per rising edge once stimulus is running.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("state", int'(state), mon_e.st);
        check("latch_release", int'(latch_release), mon_e.lr);
        check("alarm", int'(alarm), mon_e.al);
`ifdef DOOR_LATCH_UNLOCK_COUNT_EN
        check("unlock_count", int'(unlock_count), mon_e.cnt);
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios followed by randomized door/unlock/ack traffic.
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    do_reset(3);

    // Plain release window with the door kept shut.
    idle(5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(12, 1'b0, 1'b0);

    // Door opened during the window, closed again before the open limit.
    step(1'b1, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(5, 1'b1, 1'b0);
    idle(6, 1'b0, 1'b0);

    // Door held open past the limit; ack while open is ignored.
    step(1'b1, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(22, 1'b1, 1'b0);
    idle(8, 1'b1, 1'b1);
    idle(4, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);

    // Forced entry, then an unlock during the alarm.
    idle(4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b1);

    // Unlock coinciding with the synchronized door going high.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b1);

    // Window extension by a second unlock.
    step(1'b1, 1'b0, 1'b0);
    idle(5, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(16, 1'b0, 1'b0);

    // Counter saturation and reset in the middle of a release window.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(10, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    do_reset(2);

    // Randomized traffic: door held at a level for random stretches.
    for (int blk = 0; blk < 120; blk++) begin
      len = $urandom_range(1, 30);
      dr  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) do_reset(2);
      for (int i = 0; i < len; i++)
        step(1'($urandom_range(0, 5) == 0), dr, 1'($urandom_range(0, 2) == 0));
    end
    idle(4, 1'b0, 1'b1);

    // Let the monitor drain the queue, bounded.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/door_latch_ctrl.md
Name: door_latch_ctrl

Overview:
- Downstream stage of the serial-code lock FSM.
- Consumes the lock's single-cycle `out` unlock pulse and drives the physical latch release.
- Supervises the door-position sensor: times the release window, times how long the door stays open, and raises an alarm on forced entry or door-held-open.
- Moore FSM with registered outputs, a single down-counter, and a 2-flop sensor synchronizer.

Parameters:
- RELEASE_CYCLES, 8: cycles latch_release stays high waiting for the door to open; must be >= 1.
- OPEN_MAX_CYCLES, 16: max cycles the door may remain open before alarm; must be >= 1.
- CNT_W, 8: width of unlock_count (optional feature only).
- Timer width is $clog2(max(RELEASE_CYCLES, OPEN_MAX_CYCLES)) + 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- unlock, input, 1: single-cycle pulse from the lock FSM `out`.
- door_open, input, 1: raw door sensor, 1 = open; asynchronous to clk.
- ack, input, 1: operator alarm acknowledge, level.
- latch_release, output, 1: 1 = latch solenoid energised (door may open).
- alarm, output, 1: 1 = alarm active.
- state, output, 2: current FSM state for debug (LOCKED=00, RELEASE=01, OPEN=10, ALARM=11).

Behaviour:
- Reset (rst=0, async): state=LOCKED, timer=0, sync flops=0, latch_release=0, alarm=0, unlock_count=0. Deassertion takes effect at the next clk edge.
- door_open passes through two flops to produce door_s. Sensor-to-FSM latency is 2 cycles. All transitions use door_s, never raw door_open.
- Outputs are decoded from the registered state: latch_release=1 only in RELEASE; alarm=1 only in ALARM.
- LOCKED:
  - door_s=1 -> ALARM (forced entry). This has priority over a simultaneous unlock.
  - else unlock=1 -> RELEASE, timer <= RELEASE_CYCLES-1.
- RELEASE:
  - door_s=1 -> OPEN, timer <= OPEN_MAX_CYCLES-1.
  - else unlock=1 -> stay, timer reloads to RELEASE_CYCLES-1 (window extension).
  - else timer==0 -> LOCKED.
  - else timer decrements.
  - With no door activity and no further unlock, latch_release is high for exactly RELEASE_CYCLES cycles.
- OPEN:
  - door_s=0 -> LOCKED (door closed, latch re-engages).
  - else timer==0 -> ALARM (held open OPEN_MAX_CYCLES cycles).
  - else timer decrements.
  - unlock is ignored.
- ALARM:
  - ack=1 and door_s=0 -> LOCKED.
  - ack=1 with door_s=1 has no effect; the state stays in ALARM.
  - unlock is ignored.
- The timer never underflows; it is only decremented when nonzero.
- Reset mid-RELEASE or mid-ALARM: immediate return to reset values, with no glitch on latch_release beyond the async clear.

Optional Feature:
- Macro: DOOR_LATCH_UNLOCK_COUNT_EN.
- When defined:
  - Adds output unlock_count [CNT_W-1:0].
  - Increments on each accepted LOCKED->RELEASE transition only. Window-extension pulses in RELEASE do not count.
  - Saturates at all-ones; cleared only by rst.
- When undefined: the port and counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then unlock pulse at cycle 5 with door held closed -> latch_release=1 for exactly 8 cycles, then state=LOCKED, alarm=0.
- unlock, then door_open=1 at release cycle 3 for 5 cycles, then closed -> state goes RELEASE, OPEN, LOCKED (entering OPEN 2 cycles after door_open); latch_release drops on entry to OPEN; alarm stays 0.
- unlock, door opened and held 30 cycles -> ALARM after 16 cycles in OPEN. ack=1 while open -> still ALARM. Close door with ack=1 -> LOCKED 2 cycles later.
- From LOCKED, door_open=1 with no unlock -> alarm=1 two cycles later. unlock pulse during ALARM -> ignored (latch_release stays 0).
- Simultaneous unlock and door_s=1 in LOCKED -> ALARM. Separately: a second unlock at release cycle 6 -> latch_release high 6+8=14 cycles total.
- With DOOR_LATCH_UNLOCK_COUNT_EN and CNT_W=2: 5 accepted unlocks -> unlock_count reads 1, 2, 3, 3, 3. Assert rst mid-RELEASE -> count=0, latch_release=0 immediately.
